exc_irq_ctrl: RTL

Parametrised exception/interrupt sequencer for the LEGv8 core. It generalises the single-line external-interrupt handling in the control path to N_IRQ maskable request lines plus the synchronous invalid-opcode exception. It arbitrates by fixed priority, drives the `Exc`/`EStatus` pair into the datapath, and runs the acknowledge → service → `ERet` handshake as a registered state machine. It sits beside the main decoder and feeds the exception-vector mux and the ESR/ELR capture logic.

---
 rtl/exc_irq_ctrl.sv | 109 ++++++++++
 1 files changed

// File: rtl/exc_irq_ctrl.sv
// Exception/interrupt sequencer: fixed-priority arbitration of InvOp and N_IRQ maskable
// lines, then a registered PEND -> SERVICE -> ERet handshake driving Exc/EStatus.
module exc_irq_ctrl #(
  parameter int unsigned N_IRQ     = 4,
  parameter int unsigned ESTATUS_W = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 InvOp,
  input  logic                 ERet,
  input  logic                 ExcAck,
  input  logic [N_IRQ-1:0]     ExtIRQ,
  input  logic                 IrqMaskWe,
  input  logic [N_IRQ-1:0]     IrqMaskData,
  output logic                 Exc,
  output logic [ESTATUS_W-1:0] EStatus,
  output logic [N_IRQ-1:0]     ExtIAck,
  output logic                 InService,
  output logic                 DblFault
);

  typedef enum logic [1:0] {StIdle, StPend, StService} state_e;

  state_e               r_state, w_state_d;
  logic [N_IRQ-1:0]     r_irq;
  logic [N_IRQ-1:0]     r_mask;
  logic [ESTATUS_W-1:0] r_estatus, w_estatus_d;
  logic [N_IRQ-1:0]     r_ext_iack, w_ext_iack_d;
  logic                 r_dbl_fault, w_dbl_fault_d;

  logic [N_IRQ-1:0]     w_eligible;
  logic                 w_irq_hit;
  logic [ESTATUS_W-1:0] w_win_code;
  logic [N_IRQ-1:0]     w_ack_onehot;

  // Descending scan so the lowest eligible index is written last and wins.
  always_comb begin
    w_eligible = r_irq & ~r_mask;
    w_irq_hit  = |w_eligible;
    w_win_code = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (w_eligible[i]) w_win_code = ESTATUS_W'(i + 2);
    end
    w_ack_onehot = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      if (r_estatus == ESTATUS_W'(i + 2)) w_ack_onehot[i] = 1'b1;
    end
  end

  always_comb begin
    w_state_d     = r_state;
    w_estatus_d   = r_estatus;
    w_ext_iack_d  = '0;
    w_dbl_fault_d = r_dbl_fault;
    unique case (r_state)
      StIdle: begin
        if (InvOp) begin
          w_estatus_d = ESTATUS_W'(1);
          w_state_d   = StPend;
        end else if (w_irq_hit) begin
          w_estatus_d = w_win_code;
          w_state_d   = StPend;
        end
      end
      StPend: begin
        if (ExcAck) begin
          w_state_d    = StService;
          w_ext_iack_d = w_ack_onehot;
        end
      end
      StService: begin
        if (InvOp) w_dbl_fault_d = 1'b1;
        if (ERet) begin
          w_state_d   = StIdle;
          w_estatus_d = '0;
        end
      end
      default: begin
        w_state_d   = StIdle;
        w_estatus_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= StIdle;
      r_irq       <= '0;
      r_mask      <= '1;
      r_estatus   <= '0;
      r_ext_iack  <= '0;
      r_dbl_fault <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_irq       <= ExtIRQ;
      if (IrqMaskWe) r_mask <= IrqMaskData;
      r_estatus   <= w_estatus_d;
      r_ext_iack  <= w_ext_iack_d;
      r_dbl_fault <= w_dbl_fault_d;
    end
  end

  assign Exc       = (r_state == StPend);
  assign InService = (r_state == StService);
  assign EStatus   = r_estatus;
  assign ExtIAck   = r_ext_iack;
  assign DblFault  = r_dbl_fault;

endmodule
